// File: rtl/pipeline_ctrl.sv
// Hazard and stall sequencer for the KLP32 five-stage pipeline: load-use stalls,
// branch redirect flushes, data-memory wait handling, watchdog and stall counter.
module pipeline_ctrl #(
   parameter int MEM_TIMEOUT_W = 8,
   parameter int STALL_CNT_W   = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [31:0]            i_decode_inst,
   input  logic                   i_decode_valid,
   input  logic                   i_execute_valid,
   input  logic [4:0]             i_execute_rd,
   input  logic                   i_execute_reg_wr_en,
   input  logic                   i_execute_is_load,
   input  logic                   i_execute_branch_taken,
   input  logic                   i_mem_req,
   input  logic                   i_mem_ack,
   output logic                   o_pc_en,
   output logic                   o_fetch_en,
   output logic                   o_decode_en,
   output logic                   o_execute_en,
   output logic                   o_memory_en,
   output logic                   o_writeback_en,
   output logic                   o_decode_flush,
   output logic                   o_execute_flush,
   output logic [1:0]             o_state,
   output logic                   o_mem_timeout,
   output logic [STALL_CNT_W-1:0] o_stall_count
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      FLUSH    = 2'd2
   } state_t;

   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_S     = 7'b0100011;
   localparam logic [6:0] OP_B     = 7'b1100011;

   localparam logic [MEM_TIMEOUT_W-1:0] WDOG_MAX  = '1;
   localparam logic [STALL_CNT_W-1:0]   STALL_MAX = '1;

   state_t                   r_state;
   state_t                   w_next;
   logic [MEM_TIMEOUT_W-1:0] r_wdog;
   logic [MEM_TIMEOUT_W-1:0] w_wdog_next;
   logic                     r_timeout;
   logic [STALL_CNT_W-1:0]   r_stall_cnt;

   logic [6:0] w_opcode;
   logic [4:0] w_rs1;
   logic [4:0] w_rs2;
   logic       w_uses_rs1;
   logic       w_uses_rs2;
   logic       w_lu;
   logic       w_ms;
   logic       w_unused_inst_bits;

   logic w_front_en;
   logic w_back_en;
   logic w_decode_flush;
   logic w_execute_flush;
   logic w_mem_wait;
   logic w_eval_run;
   logic w_lu_eff;

   assign w_opcode = i_decode_inst[6:0];
   assign w_rs1    = i_decode_inst[19:15];
   assign w_rs2    = i_decode_inst[24:20];
   assign w_unused_inst_bits = ^{i_decode_inst[31:25], i_decode_inst[14:7]};

   assign w_uses_rs1 = !((w_opcode == OP_LUI) || (w_opcode == OP_AUIPC) || (w_opcode == OP_JAL));
   assign w_uses_rs2 = (w_opcode == OP_R) || (w_opcode == OP_S) || (w_opcode == OP_B);

   assign w_lu = i_decode_valid && i_execute_valid && i_execute_is_load && i_execute_reg_wr_en &&
                 (i_execute_rd != 5'd0) &&
                 ((w_uses_rs1 && (i_execute_rd == w_rs1)) || (w_uses_rs2 && (i_execute_rd == w_rs2)));

   assign w_ms = i_mem_req && !i_mem_ack;

   // MEM_WAIT with ack, and FLUSH, reuse the RUN priority chain; w_ms is already 0 on an ack cycle.
   always_comb begin
      w_next          = r_state;
      w_front_en      = 1'b0;
      w_back_en       = 1'b0;
      w_decode_flush  = 1'b0;
      w_execute_flush = 1'b0;
      w_mem_wait      = 1'b0;
      w_eval_run      = 1'b0;
      w_lu_eff        = w_lu;

      case (r_state)
         RUN: w_eval_run = 1'b1;
         MEM_WAIT: begin
            if (i_mem_ack) w_eval_run = 1'b1;
            else           w_mem_wait = 1'b1;
         end
         FLUSH: begin
            w_eval_run     = 1'b1;
            w_lu_eff       = 1'b0;
            w_decode_flush = 1'b1;
         end
         default: w_next = RUN;
      endcase

      if (w_eval_run) begin
         if (w_ms) begin
            w_mem_wait = 1'b1;
            w_next     = MEM_WAIT;
         end else if (i_execute_branch_taken) begin
            w_front_en      = 1'b1;
            w_back_en       = 1'b1;
            w_decode_flush  = 1'b1;
            w_execute_flush = 1'b1;
            w_next          = FLUSH;
         end else if (w_lu_eff) begin
            w_back_en       = 1'b1;
            w_execute_flush = 1'b1;
            w_next          = RUN;
         end else begin
            w_front_en = 1'b1;
            w_back_en  = 1'b1;
            w_next     = RUN;
         end
      end

      if (!reset) begin
         w_front_en      = 1'b0;
         w_back_en       = 1'b0;
         w_decode_flush  = 1'b0;
         w_execute_flush = 1'b0;
         w_mem_wait      = 1'b0;
         w_next          = RUN;
      end
   end

   assign w_wdog_next = !w_mem_wait ? '0 :
                        (r_wdog == WDOG_MAX) ? r_wdog : r_wdog + 1'b1;

   // Timeout latches the first time the watchdog reaches its ceiling and holds until reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= RUN;
         r_wdog      <= '0;
         r_timeout   <= 1'b0;
         r_stall_cnt <= '0;
      end else begin
         r_state <= w_next;
         r_wdog  <= w_wdog_next;
         if (w_wdog_next == WDOG_MAX) r_timeout <= 1'b1;
         if (!w_front_en && (r_stall_cnt != STALL_MAX)) r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign o_pc_en         = w_front_en;
   assign o_fetch_en      = w_front_en;
   assign o_decode_en     = w_front_en;
   assign o_execute_en    = w_back_en;
   assign o_memory_en     = w_back_en;
   assign o_writeback_en  = w_back_en;
   assign o_decode_flush  = w_decode_flush;
   assign o_execute_flush = w_execute_flush;
   assign o_state         = r_state;
   assign o_mem_timeout   = r_timeout;
   assign o_stall_count   = r_stall_cnt;

endmodule
